lsu_mem_ctrl: RTL and testbench

- Load/store initiator that drives the word-addressed data RAM from the execute stage.
- Converts RV32I byte addresses and funct3 sizes (LB/LH/LW/LBU/LHU, SB/SH/SW) into word-wide RAM transactions.
- Performs read-modify-write for sub-word stores, plus sign/zero extension for loads.
- Detects misaligned or out-of-range accesses and returns a one-cycle response to the pipeline.

---
 rtl/lsu_mem_ctrl_pkg.sv | 41 ++++
 rtl/lsu_mem_ctrl_align.sv | 44 ++++
 rtl/lsu_mem_ctrl.sv | 147 ++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// Purpose: shared RV32I load/store constants, FSM encoding and access-check helpers.
// Latency: n/a (package).
// Backpressure: n/a (package).
package lsu_mem_ctrl_pkg;

  // RV32I funct3 size/sign codes. Loads and stores share the low size bits.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Byte-lane geometry of a 32-bit word.
  localparam int BYTE_W     = 8;
  localparam int HALF_W     = 16;
  localparam int LANE_IDX_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_RESP    = 3'd4
  } lsu_state_e;

  // Loads: 011, 110, 111 are not defined. Stores: only 000..010 exist.
  function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 >= 3'b011);
    else          return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

  // Size comes from funct3[1:0]; bytes can never be misaligned.
  function automatic logic misaligned(input logic [2:0] f3, input logic [LANE_IDX_W-1:0] lane);
    return ((f3[1:0] == 2'b01) && lane[0]) ||
           ((f3[1:0] == 2'b10) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Purpose: combinational byte/half lane extract + sign/zero extend for loads,
//          and lane merge into the old RAM word for sub-word stores.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: i_funct3 size/sign code, i_lane = addr[1:0], i_rdata RAM word,
//        i_wdata right-aligned store data, o_load_data extended load result,
//        o_merged_data word to write back.
module lsu_align
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [2:0]            i_funct3,
  input  logic [LANE_IDX_W-1:0] i_lane,
  input  logic [DWIDTH-1:0]     i_rdata,
  input  logic [DWIDTH-1:0]     i_wdata,
  output logic [DWIDTH-1:0]     o_load_data,
  output logic [DWIDTH-1:0]     o_merged_data
);

  logic [BYTE_W-1:0] w_byte;
  logic [HALF_W-1:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_lane, 3'b000} +: BYTE_W];
    // Halfwords are aligned here, so only lane[1] selects the half.
    w_half = i_rdata[{i_lane[1], 4'b0000} +: HALF_W];

    case (i_funct3)
      F3_LB:   o_load_data = {{(DWIDTH-BYTE_W){w_byte[BYTE_W-1]}}, w_byte};
      F3_LH:   o_load_data = {{(DWIDTH-HALF_W){w_half[HALF_W-1]}}, w_half};
      F3_LBU:  o_load_data = {{(DWIDTH-BYTE_W){1'b0}}, w_byte};
      F3_LHU:  o_load_data = {{(DWIDTH-HALF_W){1'b0}}, w_half};
      default: o_load_data = i_rdata;
    endcase

    o_merged_data = i_rdata;
    case (i_funct3[1:0])
      2'b00:   o_merged_data[{i_lane, 3'b000} +: BYTE_W] = i_wdata[BYTE_W-1:0];
      2'b01:   o_merged_data[{i_lane[1], 4'b0000} +: HALF_W] = i_wdata[HALF_W-1:0];
      default: o_merged_data = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Purpose: RV32I load/store initiator driving a word-addressed RAM with
//          registered read data; RMW for SB/SH, extension for loads.
// Latency: response pulse 1 (error), 2 (SW), 3 (load), 4 (SB/SH) cycles after accept.
// Backpressure: req_ready only in IDLE; the response pulse cannot be stalled.
// Ports: clk/rst (async active-low); req_* execute-stage request;
//        resp_* one-cycle completion; mem_* RAM side (en_fetch, en_store,
//        word-index addr, wdata, rdata valid one cycle after fetch).
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DWIDTH-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_en_fetch,
  output logic              mem_en_store,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  lsu_state_e        r_state;
  lsu_state_e        w_state_nxt;
  logic [31:0]       r_addr;
  logic [2:0]        r_funct3;
  logic [DWIDTH-1:0] r_wdata;
  logic              r_is_store;
  logic [DWIDTH-1:0] r_resp_rdata;
  logic              r_resp_err;

  logic              w_accept;
  logic              w_err;
  logic [AWIDTH-1:0] w_word_idx;
  logic [DWIDTH-1:0] w_load_data;
  logic [DWIDTH-1:0] w_merged_data;

  assign w_accept   = (r_state == ST_IDLE) && req_valid;
  assign w_err      = f3_illegal(req_is_store, req_funct3) ||
                      misaligned(req_funct3, req_addr[1:0]) ||
                      ((req_addr >> 2) >= 32'(DEPTH));
  assign w_word_idx = AWIDTH'(r_addr[31:2]);

  lsu_align #(.DWIDTH(DWIDTH)) u_align (
    .i_funct3      (r_funct3),
    .i_lane        (r_addr[1:0]),
    .i_rdata       (mem_rdata),
    .i_wdata       (r_wdata),
    .o_load_data   (w_load_data),
    .o_merged_data (w_merged_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    mem_en_fetch = 1'b0;
    mem_en_store = 1'b0;
    mem_wdata    = '0;
    resp_valid   = 1'b0;
    // The index is only meaningful once a request is held.
    mem_addr     = (r_state == ST_IDLE) ? '0 : w_word_idx;
    req_ready    = (r_state == ST_IDLE) && rst;

    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_err)                      w_state_nxt = ST_RESP;
          else if (!req_is_store)         w_state_nxt = ST_RD_ADDR;
          else if (req_funct3 == F3_SW)   w_state_nxt = ST_WR;
          else                            w_state_nxt = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: begin
        mem_en_fetch = 1'b1;
        w_state_nxt  = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        w_state_nxt = r_is_store ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        mem_en_store = 1'b1;
        mem_wdata    = r_wdata;
        w_state_nxt  = ST_RESP;
      end
      ST_RESP: begin
        resp_valid  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request capture and response registers. Response fields are only
  // written on the edge entering RESP so they hold between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr       <= '0;
      r_funct3     <= '0;
      r_wdata      <= '0;
      r_is_store   <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr     <= req_addr;
        r_funct3   <= req_funct3;
        r_wdata    <= req_wdata;
        r_is_store <= req_is_store;
        if (w_err) begin
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b1;
        end
      end
      if (r_state == ST_RD_DATA) begin
        if (r_is_store) begin
          // RMW: old word with the new lane(s) becomes the write data.
          r_wdata <= w_merged_data;
        end else begin
          r_resp_rdata <= w_load_data;
          r_resp_err   <= 1'b0;
        end
      end
      if (r_state == ST_WR) begin
        r_resp_rdata <= '0;
        r_resp_err   <= 1'b0;
      end
    end
  end

  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en_fetch;
  logic        mem_en_store;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.DWIDTH(32), .AWIDTH(32), .DEPTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_en_fetch (mem_en_fetch),
    .mem_en_store (mem_en_store),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // RAM with registered read, plus enable activity counters.
  logic [31:0] ram [32];
  int fetch_cnt = 0;
  int store_cnt = 0;
  int both_cnt  = 0;

  always @(posedge clk) begin
    if (mem_en_fetch) begin
      mem_rdata <= ram[mem_addr[4:0]];
      fetch_cnt <= fetch_cnt + 1;
    end
    if (mem_en_store) begin
      ram[mem_addr[4:0]] <= mem_wdata;
      store_cnt <= store_cnt + 1;
    end
    if (mem_en_fetch && mem_en_store) both_cnt <= both_cnt + 1;
  end

  int tests  = 0;
  int failed = 0;

  // Results of the last request.
  int          lat;
  logic [31:0] o_rdata;
  logic        o_err;
  int          st_cyc;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  int          d_fetch;
  int          d_store;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it for up to 8 cycles after the accept edge.
  task automatic run_req(input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    int f0;
    int s0;
    f0 = fetch_cnt;
    s0 = store_cnt;
    lat = 0; o_rdata = 'x; o_err = 1'bx;
    st_cyc = 0; st_addr = 'x; st_wdata = 'x;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (mem_en_store && st_cyc == 0) begin
        st_cyc = k; st_addr = mem_addr; st_wdata = mem_wdata;
      end
      if (resp_valid) begin
        lat = k; o_rdata = resp_rdata; o_err = resp_err;
        break;
      end
    end
    d_fetch = fetch_cnt - f0;
    d_store = store_cnt - s0;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;

    // Reset state
    #12;
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_en_fetch", {31'b0, mem_en_fetch}, 32'd0);
    chk("rst_en_store", {31'b0, mem_en_store}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk); rst = 1'b1; #1;
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

    // Preload via word stores: word2 = 3, word1 = 0x8000
    run_req(1'b1, 3'b010, 32'h08, 32'h0000_0003);
    chk("sw_pre_lat", lat, 2);
    run_req(1'b1, 3'b010, 32'h04, 32'h0000_8000);

    // LW 0x08
    run_req(1'b0, 3'b010, 32'h08, 32'h0);
    chk("lw8_lat", lat, 3);
    chk("lw8_rdata", o_rdata, 32'h0000_0003);
    chk("lw8_err", {31'b0, o_err}, 32'd0);
    chk("lw8_fetches", d_fetch, 1);
    chk("lw8_stores", d_store, 0);
    @(negedge clk);
    chk("lw8_pulse_1cyc", {31'b0, resp_valid}, 32'd0);
    chk("lw8_rdata_hold", resp_rdata, 32'h0000_0003);

    // Sub-word loads from word1 = 0x0000_8000
    run_req(1'b0, 3'b000, 32'h05, 32'h0);
    chk("lb5_rdata", o_rdata, 32'hFFFF_FF80);
    chk("lb5_lat", lat, 3);
    run_req(1'b0, 3'b100, 32'h05, 32'h0);
    chk("lbu5_rdata", o_rdata, 32'h0000_0080);
    run_req(1'b0, 3'b001, 32'h04, 32'h0);
    chk("lh4_rdata", o_rdata, 32'hFFFF_8000);
    run_req(1'b0, 3'b101, 32'h04, 32'h0);
    chk("lhu4_rdata", o_rdata, 32'h0000_8000);

    // SB 0xAB at 0x06 over word1 = 2
    run_req(1'b1, 3'b010, 32'h04, 32'h0000_0002);
    run_req(1'b1, 3'b000, 32'h06, 32'h0000_00AB);
    chk("sb6_lat", lat, 4);
    chk("sb6_stores", d_store, 1);
    chk("sb6_fetches", d_fetch, 1);
    chk("sb6_store_cyc", st_cyc, 3);
    chk("sb6_mem_addr", st_addr, 32'd1);
    chk("sb6_mem_wdata", st_wdata, 32'h00AB_0002);
    chk("sb6_rdata", o_rdata, 32'd0);
    chk("sb6_err", {31'b0, o_err}, 32'd0);
    run_req(1'b0, 3'b010, 32'h04, 32'h0);
    chk("sb6_readback", o_rdata, 32'h00AB_0002);

    // SW 0xDEADBEEF at 0x0C
    run_req(1'b1, 3'b010, 32'h0C, 32'hDEAD_BEEF);
    chk("swc_lat", lat, 2);
    chk("swc_store_cyc", st_cyc, 1);
    chk("swc_mem_addr", st_addr, 32'd3);
    chk("swc_mem_wdata", st_wdata, 32'hDEAD_BEEF);
    chk("swc_fetches", d_fetch, 0);
    run_req(1'b0, 3'b010, 32'h0C, 32'h0);
    chk("swc_readback", o_rdata, 32'hDEAD_BEEF);

    // SH into upper half of word3
    run_req(1'b1, 3'b001, 32'h0E, 32'h1234_5678);
    chk("sh_e_lat", lat, 4);
    chk("sh_e_mem_wdata", st_wdata, 32'h5678_BEEF);
    run_req(1'b0, 3'b101, 32'h0E, 32'h0);
    chk("lhu_e_rdata", o_rdata, 32'h0000_5678);

    // Error cases: one-cycle response, no RAM activity
    run_req(1'b0, 3'b010, 32'h02, 32'h0);
    chk("lw2_lat", lat, 1);
    chk("lw2_err", {31'b0, o_err}, 32'd1);
    chk("lw2_rdata", o_rdata, 32'd0);
    chk("lw2_enables", d_fetch + d_store, 0);
    run_req(1'b1, 3'b001, 32'h03, 32'hFFFF_FFFF);
    chk("sh3_lat", lat, 1);
    chk("sh3_err", {31'b0, o_err}, 32'd1);
    chk("sh3_enables", d_fetch + d_store, 0);
    run_req(1'b0, 3'b010, 32'h80, 32'h0);
    chk("lw80_lat", lat, 1);
    chk("lw80_err", {31'b0, o_err}, 32'd1);
    chk("lw80_enables", d_fetch + d_store, 0);
    run_req(1'b0, 3'b011, 32'h00, 32'h0);
    chk("ld_f3_011_err", {31'b0, o_err}, 32'd1);
    run_req(1'b1, 3'b100, 32'h00, 32'h0);
    chk("st_f3_100_err", {31'b0, o_err}, 32'd1);
    chk("st_f3_100_enables", d_fetch + d_store, 0);

    // Last in-range word (index 31)
    run_req(1'b1, 3'b010, 32'h7C, 32'h1357_9BDF);
    chk("sw7c_err", {31'b0, o_err}, 32'd0);
    chk("sw7c_mem_addr", st_addr, 32'd31);
    run_req(1'b0, 3'b010, 32'h7C, 32'h0);
    chk("lw7c_rdata", o_rdata, 32'h1357_9BDF);
    chk("lw7c_err", {31'b0, o_err}, 32'd0);

    // Reset asserted during RD_DATA of an SB
    begin
      int s0;
      s0 = store_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b000;
      req_addr = 32'h04; req_wdata = 32'h0000_0011;
      @(posedge clk);
      @(negedge clk); req_valid = 1'b0;
      chk("rsb_fetch_rd_addr", {31'b0, mem_en_fetch}, 32'd1);
      @(negedge clk);
      rst = 1'b0; #1;
      chk("rsb_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rsb_resp_rdata", resp_rdata, 32'd0);
      chk("rsb_resp_err", {31'b0, resp_err}, 32'd0);
      chk("rsb_en_fetch", {31'b0, mem_en_fetch}, 32'd0);
      chk("rsb_en_store", {31'b0, mem_en_store}, 32'd0);
      chk("rsb_mem_addr", mem_addr, 32'd0);
      chk("rsb_mem_wdata", mem_wdata, 32'd0);
      chk("rsb_req_ready", {31'b0, req_ready}, 32'd0);
      repeat (3) @(negedge clk);
      chk("rsb_no_store", store_cnt - s0, 0);
      rst = 1'b1; #1;
      chk("rsb_ready_after", {31'b0, req_ready}, 32'd1);
    end
    run_req(1'b0, 3'b010, 32'h04, 32'h0);
    chk("post_rst_lw_lat", lat, 3);
    chk("post_rst_lw_rdata", o_rdata, 32'h00AB_0002);

    chk("fetch_store_overlap", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
